seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit common-anode 7-segment display.
- Sequences the shared combinational BCD-to-7-segment decoder across all 8 digits: drives one BCD nibble plus one active-low anode per time slot.
- Holds a double-buffered display register so frame updates never tear.
- Inserts a blanking interval between digits to suppress ghosting; handles leading-zero blanking, per-digit enables and decimal points.

---
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Steps one BCD nibble and one active-low anode per digit slot, with a blanking
// interval at the start of each slot, a double-buffered display register swapped
// only at the frame boundary, and leading-zero / per-digit / invalid-BCD blanking.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   wr_en         one-cycle strobe capturing wr_data/wr_dp into the pending buffer
//   wr_data       8 BCD nibbles, [3:0] = digit0 (rightmost) .. [31:28] = digit7
//   wr_dp         decimal point per digit, 1 = on
//   digit_en      live per-digit enable mask, 1 = digit may light
//   lz_blank      live leading-zero blanking enable
//   bcd           nibble to the shared decoder
//   an            active-low anodes
//   dp_n          active-low decimal point
//   wr_ack        one-cycle pulse: pending data became active
//   frame_start   one-cycle pulse: first cycle of the digit-0 slot
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  bcd,
  output logic [7:0]  an,
  output logic        dp_n,
  output logic        wr_ack,
  output logic        frame_start
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t           state, state_nxt;
  logic             run;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [31:0]      act_data, act_data_nxt, pend_data;
  logic [7:0]       act_dp, act_dp_nxt, pend_dp;
  logic             pend;
  logic             boundary, swap;
  logic [7:0]       hi_zero;
  logic             zero_run;
  logic [3:0]       nib;
  logic             suppress, lit;

  // Slot position for the next cycle. The first cycle after reset release holds
  // position (0,0) so that the registered outputs show slot position 0 with
  // frame_start while cnt==0.
  always_comb begin
    cnt_nxt  = cnt;
    idx_nxt  = idx;
    boundary = run && (idx == 3'd7) && (cnt == CNT_MAX);
    swap     = boundary && (pend || wr_en);
    if (run) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt = '0;
        idx_nxt = idx + 3'd1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Active buffer as seen in the next cycle; a write at the boundary wins over pending.
  always_comb begin
    act_data_nxt = act_data;
    act_dp_nxt   = act_dp;
    if (swap) begin
      act_data_nxt = wr_en ? wr_data : pend_data;
      act_dp_nxt   = wr_en ? wr_dp   : pend_dp;
    end
  end

  // Blank/drive phase within a slot.
  always_comb begin
    state_nxt = state;
    if (cnt_nxt == '0) begin
      state_nxt = ST_BLANK;
    end else if (cnt_nxt == CNT_BLANK) begin
      state_nxt = ST_DRIVE;
    end
  end

  // hi_zero[i]: every nibble at positions >= i is zero.
  always_comb begin
    zero_run = 1'b1;
    hi_zero  = '0;
    for (int i = 7; i >= 0; i--) begin
      zero_run   = zero_run && (act_data_nxt[4*i +: 4] == 4'd0);
      hi_zero[i] = zero_run;
    end
    nib      = act_data_nxt[{idx_nxt, 2'b00} +: 4];
    suppress = !digit_en[idx_nxt] || (nib > 4'd9) ||
               (lz_blank && (idx_nxt != 3'd0) && hi_zero[idx_nxt]);
    lit      = (state_nxt == ST_DRIVE) && !suppress;
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= '0;
      act_data    <= '0;
      act_dp      <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend        <= 1'b0;
      bcd         <= '0;
      an          <= 8'hFF;
      dp_n        <= 1'b1;
      wr_ack      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      run      <= 1'b1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      act_data <= act_data_nxt;
      act_dp   <= act_dp_nxt;
      if (swap) begin
        pend <= 1'b0;
      end else if (wr_en) begin
        pend      <= 1'b1;
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
      end
      bcd         <= nib;
      an          <= lit ? ~(8'd1 << idx_nxt) : 8'hFF;
      dp_n        <= lit ? ~act_dp_nxt[idx_nxt] : 1'b1;
      wr_ack      <= swap;
      frame_start <= !run || boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

  localparam int unsigned RDIV  = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = 8 * RDIV;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] bcd;
    logic       dp_n;
    logic       fs;
    logic       ack;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  bcd;
  logic [7:0]  an;
  logic        dp_n;
  logic        wr_ack;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  obs_t exp_q[$];

  // Bench view of the displayed frame.
  logic [31:0] cur_data;
  logic [7:0]  cur_dp;
  logic        exp_ack_now;

  seg_scan_ctrl #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .digit_en(digit_en), .lz_blank(lz_blank), .bcd(bcd), .an(an), .dp_n(dp_n),
    .wr_ack(wr_ack), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for frame cycle (idx,pos) of a given display.
  function automatic obs_t model(input logic [31:0] d, input logic [7:0] dp,
                                 input logic [7:0] den, input logic lz,
                                 input int idx, input int pos, input logic ack);
    obs_t o;
    int hi;
    logic [3:0] n;
    logic sup;
    hi = -1;
    for (int i = 0; i < 8; i++) if (d[4*i +: 4] != 4'd0) hi = i;
    n   = d[4*idx +: 4];
    sup = !den[idx] || (n > 4'd9) || (lz && idx > 0 && idx > hi);
    o.bcd = n;
    o.fs  = (idx == 0) && (pos == 0);
    o.ack = ack && o.fs;
    if (pos >= int'(BLANK) && !sup) begin
      o.an   = ~(8'd1 << idx);
      o.dp_n = ~dp[idx];
    end else begin
      o.an   = 8'hFF;
      o.dp_n = 1'b1;
    end
    return o;
  endfunction

  task automatic push_cycles(input int start, input int n, input logic [31:0] d,
                             input logic [7:0] dp, input logic [7:0] den,
                             input logic lz, input logic ack);
    for (int c = start; c < start + n; c++)
      exp_q.push_back(model(d, dp, den, lz, c / int'(RDIV), c % int'(RDIV), ack));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one expectation per cycle and compare with the sampled outputs.
  task automatic drain(input int n, input string name);
    obs_t got, exp;
    for (int i = 0; i < n; i++) begin
      got.an = an; got.bcd = bcd; got.dp_n = dp_n; got.fs = frame_start; got.ack = wr_ack;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s step %0d: scoreboard empty, got an=%h bcd=%h", name, i, an, bcd);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL %s step %0d: got an=%h bcd=%h dp_n=%b fs=%b ack=%b, want an=%h bcd=%h dp_n=%b fs=%b ack=%b",
                   name, i, got.an, got.bcd, got.dp_n, got.fs, got.ack,
                   exp.an, exp.bcd, exp.dp_n, exp.fs, exp.ack);
        end
      end
      tick();
    end
  endtask

  // Write at the first cycle of a frame, then show the old and the new frame.
  task automatic show_write(input logic [31:0] d, input logic [7:0] dp, input string name);
    wr_en = 1'b1; wr_data = d; wr_dp = dp;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, exp_ack_now);
    drain(1, name);
    wr_en = 1'b0;
    drain(FRAME - 1, name);
    cur_data = d; cur_dp = dp; exp_ack_now = 1'b1;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b1);
    drain(FRAME, name);
    exp_ack_now = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dp = '0;
    digit_en = 8'hFF; lz_blank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({an, bcd, dp_n, wr_ack, frame_start} !== {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got an=%h bcd=%h dp_n=%b ack=%b fs=%b, want an=ff bcd=0 dp_n=1 ack=0 fs=0",
               an, bcd, dp_n, wr_ack, frame_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cur_data = '0; cur_dp = '0; exp_ack_now = 1'b0;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(FRAME, "reset_first_frame");
  endtask

  task automatic test_write_timing();
    push_cycles(0, 24, cur_data, cur_dp, digit_en, lz_blank, exp_ack_now);
    drain(24, "wt_before");
    wr_en = 1'b1; wr_data = 32'h87654321; wr_dp = 8'h01;
    push_cycles(24, FRAME - 24, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(1, "wt_old");
    wr_en = 1'b0;
    drain(FRAME - 25, "wt_old");
    cur_data = 32'h87654321; cur_dp = 8'h01;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b1);
    drain(FRAME, "wt_new");
    exp_ack_now = 1'b0;
  endtask

  task automatic test_leading_zero();
    lz_blank = 1'b1;
    show_write(32'h00000420, 8'h00, "lz_420");
    show_write(32'h00040020, 8'h00, "lz_40020");
    show_write(32'h00000000, 8'h00, "lz_zero");
    lz_blank = 1'b0;
  endtask

  task automatic test_masking();
    show_write(32'h87654A21, 8'h04, "mask_invalid");
    digit_en = 8'h0F;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, exp_ack_now);
    drain(FRAME, "mask_en0f");
    push_cycles(0, 37, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(37, "mask_live");
    digit_en = 8'hFF;
    push_cycles(37, 1, cur_data, cur_dp, 8'h0F, lz_blank, 1'b0);
    push_cycles(38, FRAME - 38, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(FRAME - 37, "mask_live");
  endtask

  task automatic test_back_to_back();
    // Two writes in one frame: last wins, one ack.
    wr_en = 1'b1; wr_data = 32'h11111111; wr_dp = 8'h00;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(1, "b2b_old");
    wr_en = 1'b0;
    drain(9, "b2b_old");
    wr_en = 1'b1; wr_data = 32'h22222222; wr_dp = 8'h80;
    drain(1, "b2b_old");
    wr_en = 1'b0;
    drain(FRAME - 11, "b2b_old");
    cur_data = 32'h22222222; cur_dp = 8'h80;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b1);
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(2 * FRAME, "b2b_new");
    // Write exactly on the boundary cycle.
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(FRAME - 1, "bnd_old");
    wr_en = 1'b1; wr_data = 32'h33333333; wr_dp = 8'h02;
    drain(1, "bnd_old");
    wr_en = 1'b0;
    cur_data = 32'h33333333; cur_dp = 8'h02;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b1);
    drain(FRAME, "bnd_new");
    exp_ack_now = 1'b0;
  endtask

  task automatic test_reset_midframe();
    show_write(32'h87654321, 8'h00, "rm_load");
    wr_en = 1'b1; wr_data = 32'h99999999; wr_dp = 8'hFF;
    push_cycles(0, 43, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(1, "rm_pre");
    wr_en = 1'b0;
    drain(42, "rm_pre");
    checks++;
    if ({an, bcd} !== {8'hDF, 4'h6}) begin
      failures++;
      $display("FAIL rm_idx5: got an=%h bcd=%h, want an=df bcd=6", an, bcd);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an, bcd, dp_n, wr_ack, frame_start} !== {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rm_async: got an=%h bcd=%h dp_n=%b ack=%b fs=%b, want an=ff bcd=0 dp_n=1 ack=0 fs=0",
               an, bcd, dp_n, wr_ack, frame_start);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cur_data = '0; cur_dp = '0; exp_ack_now = 1'b0;
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    push_cycles(0, FRAME, cur_data, cur_dp, digit_en, lz_blank, 1'b0);
    drain(2 * FRAME, "rm_after");
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_leading_zero();
    test_masking();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
